// File: rtl/adc_spi_responder.sv
// ADC-side responder for the conv/sclk/data serial link: serializes a queued
// sample MSB first on miso, updating only on synchronized sclk falling edges.
module adc_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int LEAD_BITS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_in,
  input  logic              conv_in,
  output logic              miso,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              underrun,
  output logic [15:0]       frame_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, LEAD, DATA, TAIL} state_t;

  localparam int CW = $clog2(DATA_W + LEAD_BITS + 1);
  localparam logic [CW-1:0] LEAD_LAST = CW'((LEAD_BITS > 0) ? LEAD_BITS - 1 : 0);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sclk_sync, conv_sync;
  logic                   sclk_hist, conv_hist;
  logic                   sclk_fall, conv_fall, conv_rise;

  // Synchronizers park at the idle line levels (sclk low, conv high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      conv_sync <= '1;
      sclk_hist <= 1'b0;
      conv_hist <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      conv_sync <= {conv_sync[SYNC_STAGES-2:0], conv_in};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      conv_hist <= conv_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_fall = sclk_hist & ~sclk_sync[SYNC_STAGES-1];
  assign conv_fall = conv_hist & ~conv_sync[SYNC_STAGES-1];
  assign conv_rise = ~conv_hist & conv_sync[SYNC_STAGES-1];

  state_t            state, state_n;
  logic [CW-1:0]     bit_cnt, cnt_n;
  logic [DATA_W-1:0] shift_q, shift_n, last_q, last_n, pend_data, start_word;
  logic              pend_full, accept, start;
  logic              miso_n, done_n, abort_n, under_n;
  logic [15:0]       count_n;

  // Handshake: a sample transfers on any clk where sample_valid && sample_ready;
  // ready is simply "pending empty" and depends on nothing combinational.
  assign sample_ready = ~pend_full;
  assign accept       = sample_valid & sample_ready;
  assign start        = (state == IDLE) & conv_fall;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_full <= 1'b0;
      pend_data <= '0;
    end else if (start) begin
      pend_full <= 1'b0;
    end else if (accept) begin
      pend_full <= 1'b1;
      pend_data <= sample_data;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    shift_n = shift_q;
    last_n  = last_q;
    miso_n  = miso;
    done_n  = 1'b0;
    abort_n = 1'b0;
    under_n = 1'b0;
    count_n = frame_count;
    // A sample arriving in the conv_fall clk bypasses the empty buffer.
    start_word = pend_full ? pend_data : (accept ? sample_data : last_q);
    if ((state != IDLE) && conv_rise) begin
      state_n = IDLE;
      miso_n  = 1'b0;
      if (state == TAIL) begin
        done_n  = 1'b1;
        count_n = frame_count + 16'd1;
      end else begin
        abort_n = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          miso_n = 1'b0;
          if (conv_fall) begin
            shift_n = start_word;
            last_n  = start_word;
            under_n = ~pend_full & ~accept;
            cnt_n   = '0;
            if (LEAD_BITS == 0) begin
              state_n = DATA;
              miso_n  = start_word[DATA_W-1];
            end else begin
              state_n = LEAD;
            end
          end
        end
        LEAD: begin
          miso_n = 1'b0;
          if (sclk_fall) begin
            if (bit_cnt == LEAD_LAST) begin
              state_n = DATA;
              miso_n  = shift_q[DATA_W-1];
              cnt_n   = '0;
            end else begin
              cnt_n = bit_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (sclk_fall) begin
            shift_n = shift_q << 1;
            cnt_n   = bit_cnt + 1'b1;
            if (bit_cnt == DATA_LAST) begin
              state_n = TAIL;
              miso_n  = 1'b0;
            end else begin
              miso_n = shift_q[DATA_W-2];
            end
          end
        end
        default: miso_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      last_q      <= '0;
      miso        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      bit_cnt     <= cnt_n;
      shift_q     <= shift_n;
      last_q      <= last_n;
      miso        <= miso_n;
      frame_done  <= done_n;
      frame_abort <= abort_n;
      underrun    <= under_n;
      frame_count <= count_n;
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: a master model drives conv/sclk at clk/8 and
// samples miso on its rising edges; a buffer/count model predicts each frame.
module tb_adc_spi_responder;
  localparam int DW = 12, LB = 2, SYNC = 2, HALF = 4;

  logic          clk = 1'b0;
  logic          reset, sclk_in, conv_in, sample_valid;
  logic [DW-1:0] sample_data;
  logic          miso, sample_ready, busy, frame_done, frame_abort, underrun;
  logic [15:0]   frame_count;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  adc_spi_responder #(.DATA_W(DW), .LEAD_BITS(LB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .conv_in(conv_in), .miso(miso),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort), .underrun(underrun),
    .frame_count(frame_count), .dbg_state(dbg_state)
  );

  int total = 0, bad = 0;
  int n_done, n_abort, n_under;
  bit chk_en = 1'b0;

  // Model of the responder's buffer and frame counter.
  bit            m_full = 1'b0;
  logic [DW-1:0] m_pend = '0, m_last = '0;
  logic [15:0]   m_count = '0, prev_fc;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Per-cycle checks: idle line is quiet, and the count moves only with frame_done.
  always @(negedge clk) begin
    logic [15:0] nxt;
    if (reset || !chk_en) begin
      prev_fc = m_count;
    end else begin
      nxt = prev_fc + 16'(frame_done);
      if (!busy) check("idle_miso", miso, 0);
      check("fc_step", frame_count, nxt);
      prev_fc = nxt;
      n_done  += int'(frame_done);
      n_abort += int'(frame_abort);
      n_under += int'(underrun);
    end
  end

  task automatic load_sample(input logic [DW-1:0] v);
    @(negedge clk);
    check("ready_before_load", sample_ready, !m_full);
    sample_valid = 1'b1;
    sample_data  = v;
    @(negedge clk);
    sample_valid = 1'b0;
    check("ready_after_load", sample_ready, 0);
    m_full = 1'b1;
    m_pend = v;
  endtask

  task automatic run_frame(input int periods, input bit coincide, input bit race,
                           input logic [DW-1:0] race_v, output logic [DW-1:0] rx);
    logic [DW-1:0] word, exp_word;
    bit            exp_under, reach;
    logic          exp_bit;
    int            err_bits;
    if (race) begin
      word = race_v;
      exp_under = 1'b0;
    end else begin
      word = m_full ? m_pend : m_last;
      exp_under = !m_full;
    end
    m_last = word;
    m_full = 1'b0;
    exp_q.push_back(word);
    reach = (periods >= LB + DW);
    n_done = 0; n_abort = 0; n_under = 0; err_bits = 0; rx = '0;
    @(negedge clk);
    conv_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (race && k == SYNC - 1) begin
        sample_valid = 1'b1;
        sample_data  = race_v;
      end
      if (race && k == SYNC) sample_valid = 1'b0;
    end
    check("busy_in_frame", busy, 1);
    if (race) check("race_ready", sample_ready, 1);
    for (int p = 0; p < periods; p++) begin
      exp_bit = (p >= LB && p < LB + DW) ? word[DW-1-(p-LB)] : 1'b0;
      if (miso !== exp_bit) err_bits++;
      if (p >= LB && p < LB + DW) rx = {rx[DW-2:0], miso};
      sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_in = 1'b0;
      if (coincide && p == periods - 1) conv_in = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    conv_in = 1'b1;
    repeat (8) @(negedge clk);
    exp_word = exp_q.pop_front();
    check("serial_bits", err_bits, 0);
    if (reach) begin
      check("sb_word", rx, exp_word);
      m_count = m_count + 16'd1;
    end
    check("done_pulses", n_done, reach ? 1 : 0);
    check("abort_pulses", n_abort, reach ? 0 : 1);
    check("underrun_pulses", n_under, exp_under ? 1 : 0);
    check("frame_count", frame_count, m_count);
    check("busy_after", busy, 0);
    check("miso_after", miso, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sclk_in = 1'b0; conv_in = 1'b1; sample_valid = 1'b0; sample_data = '0;
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_done", frame_done, 0);
    check("rst_abort", frame_abort, 0);
    check("rst_underrun", underrun, 0);
    check("rst_count", frame_count, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk_en = 1'b1;

    // Basic frame.
    load_sample(12'hA5C);
    run_frame(LB + DW + 2, 1'b0, 1'b0, '0, got);
    check("a5c_word", got, 12'hA5C);
    check("a5c_done", n_done, 1);
    check("a5c_count", frame_count, 1);
    check("a5c_ready", sample_ready, 1);

    // Back-to-back with a load during the frame, then an underrun repeat.
    load_sample(12'h001);
    fork
      run_frame(LB + DW + 2, 1'b0, 1'b0, '0, got);
      begin
        repeat (12) @(negedge clk);
        load_sample(12'hFFF);
      end
    join
    check("b2b_first", got, 12'h001);
    run_frame(LB + DW + 2, 1'b0, 1'b0, '0, got);
    check("b2b_second", got, 12'hFFF);
    run_frame(LB + DW + 2, 1'b0, 1'b0, '0, got);
    check("b2b_repeat", got, 12'hFFF);
    check("b2b_underrun", n_under, 1);
    check("b2b_count", frame_count, 4);

    // Abort after 6 data bits, then a clean restart.
    load_sample(12'h3C3);
    run_frame(LB + 6, 1'b0, 1'b0, '0, got);
    check("abort_bits", got, 12'h00F);
    check("abort_pulse", n_abort, 1);
    check("abort_count", frame_count, 4);
    run_frame(LB + DW + 2, 1'b0, 1'b0, '0, got);
    check("restart_word", got, 12'h3C3);

    // Sample offered in the same clk as the synchronized conv_fall.
    run_frame(LB + DW + 2, 1'b0, 1'b1, 12'h123, got);
    check("race_word", got, 12'h123);
    check("race_underrun", n_under, 0);
    check("race_ready_end", sample_ready, 1);

    // Async reset in the middle of DATA (5 data bits in).
    load_sample(12'h555);
    @(negedge clk);
    conv_in = 1'b0;
    repeat (8) @(negedge clk);
    for (int p = 0; p < LB + 5; p++) begin
      sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_in = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    check("pre_rst_busy", busy, 1);
    #2;
    reset = 1'b1;
    m_full = 1'b0; m_last = '0; m_count = '0;
    #1;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", sample_ready, 1);
    check("mid_rst_count", frame_count, 0);
    conv_in = 1'b1;
    sclk_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    run_frame(LB + DW + 2, 1'b0, 1'b0, '0, got);
    check("post_rst_word", got, 12'h000);
    check("post_rst_underrun", n_under, 1);

    // Counter wrap: preset near the top, then two full frames.
    @(negedge clk);
    chk_en = 1'b0;
    m_count = 16'hFFFE;
    force dut.frame_count = 16'hFFFE;
    repeat (2) @(negedge clk);
    release dut.frame_count;
    @(negedge clk);
    chk_en = 1'b1;
    run_frame(LB + DW + 2, 1'b0, 1'b0, '0, got);
    check("wrap_ffff", frame_count, 16'hFFFF);
    load_sample(12'h7E1);
    run_frame(LB + DW + 2, 1'b1, 1'b0, '0, got);
    check("wrap_zero", frame_count, 16'h0000);
    check("wrap_single_done", n_done, 1);
    check("wrap_word", got, 12'h7E1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
